// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer
//   I2S receiver for an external I2S master (sck/ws/sd). The three I2S lines
//   are synchronized into the clk domain, and a bit is taken on each sck
//   rising edge detected there. Signed AUDIO_DW-bit left/right words are
//   deserialized MSB first with the standard one-bit delay after a ws change.
//   Each complete stereo frame is presented with a one-cycle valid strobe.
//   Requires f_clk >= 4*f_sck.
//
//   Handshake: valid_o is a pure strobe with no backpressure. l_data_o and
//   r_data_o change only in the cycle valid_o is high, and hold otherwise.
//
// Optional feature (macro I2S_RX_PEAK_EN):
//   defined   - peak_o tracks max |sample| over delivered frames (saturating
//               abs). err_clr_i also clears it, but a same-cycle update wins.
//   undefined - peak_o is tied to 0.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   sck_i      I2S bit clock (async)
//   ws_i       I2S word select, 0 = left, 1 = right (async)
//   sd_i       I2S serial data (async)
//   err_clr_i  level clear for err_o (and peak_o when enabled)
//   l_data_o   last complete left word
//   r_data_o   last complete right word
//   valid_o    1-clk pulse, new L/R pair on l_data_o/r_data_o
//   err_o      sticky framing error
//   peak_o     peak |sample| (0 when the peak feature is not built)
module i2s_rx_deserializer #(
    parameter int AUDIO_DW    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck_i,
    input  logic                ws_i,
    input  logic                sd_i,
    input  logic                err_clr_i,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [AUDIO_DW-1:0] peak_o
);
    localparam int DW = AUDIO_DW;
    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    // Synchronizers: all three lines see the same delay so they stay aligned.
    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic sck_s, ws_s, sd_s, sck_q, rise;

    state_t        state, state_nxt;
    logic [DW-1:0] shreg, shreg_nxt;
    logic [CW-1:0] bitcnt, bitcnt_nxt;
    logic          ws_q, ws_q_nxt;
    // primed: ws_q holds a real sampled ws value. Without it the first rise
    // after reset would compare against the reset value of ws_q and treat a
    // start in the right half as a ws change, misaligning the first word.
    logic          primed, primed_nxt;
    logic [DW-1:0] l_hold, l_hold_nxt;
    logic          l_ok, l_ok_nxt;
    logic [DW-1:0] l_data_nxt, r_data_nxt;
    logic          valid_nxt, err_nxt;
    logic [DW-1:0] word;
    logic          word_end;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_q;
    assign word  = {shreg[DW-2:0], sd_s};
    assign word_end = rise & primed & (ws_s != ws_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_q    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_i};
            sck_q    <= sck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            shreg    <= '0;
            bitcnt   <= '0;
            ws_q     <= 1'b0;
            primed   <= 1'b0;
            l_hold   <= '0;
            l_ok     <= 1'b0;
            l_data_o <= '0;
            r_data_o <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bitcnt   <= bitcnt_nxt;
            ws_q     <= ws_q_nxt;
            primed   <= primed_nxt;
            l_hold   <= l_hold_nxt;
            l_ok     <= l_ok_nxt;
            l_data_o <= l_data_nxt;
            r_data_o <= r_data_nxt;
            valid_o  <= valid_nxt;
            err_o    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        ws_q_nxt   = ws_q;
        primed_nxt = primed;
        l_hold_nxt = l_hold;
        l_ok_nxt   = l_ok;
        l_data_nxt = l_data_o;
        r_data_nxt = r_data_o;
        valid_nxt  = 1'b0;
        // A new error below overrides this clear.
        err_nxt    = err_o & ~err_clr_i;

        if (rise) begin
            shreg_nxt  = word;
            ws_q_nxt   = ws_s;
            primed_nxt = 1'b1;
            if (bitcnt != CNT_MAX) begin
                bitcnt_nxt = bitcnt + 1'b1;
            end
            if (word_end) begin
                bitcnt_nxt = '0;
                case (state)
                    HUNT: state_nxt = RUN;
                    RUN: begin
                        if (bitcnt == CNT_LAST) begin
                            if (!ws_q) begin
                                l_hold_nxt = word;
                                l_ok_nxt   = 1'b1;
                            end else if (l_ok) begin
                                l_data_nxt = l_hold;
                                r_data_nxt = word;
                                valid_nxt  = 1'b1;
                                l_ok_nxt   = 1'b0;
                            end
                            // Right word without a held left is a start-up
                            // half frame: dropped silently.
                        end else begin
                            err_nxt  = 1'b1;
                            l_ok_nxt = 1'b0;
                        end
                    end
                    default: state_nxt = HUNT;
                endcase
            end
        end
    end

`ifdef I2S_RX_PEAK_EN
    // Two's-complement magnitude; the most negative code saturates.
    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] v);
        if (!v[DW-1]) begin
            abs_sat = v;
        end else if (v[DW-2:0] == '0) begin
            abs_sat = {1'b0, {(DW-1){1'b1}}};
        end else begin
            abs_sat = -v;
        end
    endfunction

    logic [DW-1:0] peak_q, peak_nxt, l_abs, r_abs;

    always_comb begin
        l_abs    = abs_sat(l_data_nxt);
        r_abs    = abs_sat(r_data_nxt);
        // A clear in the same cycle as an update restarts from the new pair.
        peak_nxt = err_clr_i ? '0 : peak_q;
        if (valid_nxt) begin
            if (l_abs > peak_nxt) peak_nxt = l_abs;
            if (r_abs > peak_nxt) peak_nxt = r_abs;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_nxt;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
module tb_i2s_rx_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck_i = 1'b0;
    logic       ws_i = 1'b0;
    logic       sd_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [7:0] l_data_o, r_data_o, peak_o;
    logic       valid_o, err_o;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [7:0] last_l = 8'h00;
    logic [7:0] last_r = 8'h00;

    i2s_rx_deserializer #(.AUDIO_DW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
        .err_clr_i(err_clr_i), .l_data_o(l_data_o), .r_data_o(r_data_o),
        .valid_o(valid_o), .err_o(err_o), .peak_o(peak_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- valid monitor ----------------
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            vcount = vcount + 1;
            last_l = l_data_o;
            last_r = r_data_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sck period (8 clk): data and ws change while sck is low.
    task automatic send_slot(input logic ws, input logic sd);
        sck_i = 1'b0;
        ws_i  = ws;
        sd_i  = sd;
        clks(4);
        sck_i = 1'b1;
        clks(4);
    endtask

    // nbits MSB-first bits of d; the LSB slot already carries the next ws.
    task automatic send_word(input logic ws, input logic [7:0] d,
                             input logic ws_next, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_slot((i == nbits - 1) ? ws_next : ws, d[nbits-1-i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] r);
        send_word(1'b0, l, 1'b1, 8);
        send_word(1'b1, r, 1'b0, 8);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int v0;
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        clks(1);
        checks++; if (l_data_o !== 8'h00) begin errors++; $display("FAIL reset_l: got %h want 00", l_data_o); end
        checks++; if (r_data_o !== 8'h00) begin errors++; $display("FAIL reset_r: got %h want 00", r_data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if (peak_o !== 8'h00) begin errors++; $display("FAIL reset_peak: got %h want 00", peak_o); end
        checks++; if (dut.state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want HUNT(0)", dut.state); end
        v0 = vcount;
        for (int i = 0; i < 20; i++) send_slot(1'b0, i[0]);
        clks(8);
        checks++; if (vcount !== v0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", vcount - v0); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", err_o); end
        checks++; if (l_data_o !== 8'h00 || r_data_o !== 8'h00) begin errors++; $display("FAIL idle_data: got %h/%h want 00/00", l_data_o, r_data_o); end
    endtask

    task automatic test_nominal;
        int v0;
        v0 = vcount;
        send_frame(8'hFF, 8'hFF);
        clks(8);
        checks++; if (vcount !== v0) begin errors++; $display("FAIL hunt_frame_valid: got %0d pulses want 0", vcount - v0); end
        send_frame(8'hA5, 8'h3C);
        clks(8);
        checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL nominal_valid: got %0d pulses want 1", vcount - v0); end
        checks++; if (last_l !== 8'hA5) begin errors++; $display("FAIL nominal_l: got %h want a5", last_l); end
        checks++; if (last_r !== 8'h3C) begin errors++; $display("FAIL nominal_r: got %h want 3c", last_r); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL nominal_err: got %b want 0", err_o); end
        // Outputs hold while the bus is idle.
        clks(20);
        checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL hold_valid: got %0d pulses want 1", vcount - v0); end
        checks++; if (l_data_o !== 8'hA5 || r_data_o !== 8'h3C) begin errors++; $display("FAIL hold_data: got %h/%h want a5/3c", l_data_o, r_data_o); end
    endtask

    task automatic test_framing_error;
        int v0;
        v0 = vcount;
        send_word(1'b0, 8'h55, 1'b1, 7);
        send_word(1'b1, 8'h00, 1'b0, 8);
        clks(8);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", err_o); end
        checks++; if (vcount !== v0) begin errors++; $display("FAIL ferr_novalid: got %0d pulses want 0", vcount - v0); end
        send_frame(8'h11, 8'h22);
        clks(8);
        checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL ferr_recover_valid: got %0d pulses want 1", vcount - v0); end
        checks++; if (last_l !== 8'h11 || last_r !== 8'h22) begin errors++; $display("FAIL ferr_recover_data: got %h/%h want 11/22", last_l, last_r); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b want 1", err_o); end
        err_clr_i = 1'b1;
        clks(1);
        err_clr_i = 1'b0;
        clks(1);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", err_o); end
    endtask

    // ws toggles on consecutive rises while err_clr_i is held: set wins.
    task automatic test_ws_toggle;
        err_clr_i = 1'b1;
        sck_i = 1'b0;
        ws_i  = 1'b1;
        sd_i  = 1'b0;
        clks(4);
        sck_i = 1'b1;
        clks(3);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL toggle_set_beats_clr: got %b want 1", err_o); end
        clks(1);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL toggle_clr_after: got %b want 0", err_o); end
        err_clr_i = 1'b0;
        send_slot(1'b0, 1'b0);
        clks(4);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL toggle_err: got %b want 1", err_o); end
    endtask

    task automatic test_startup_midframe;
        int v0;
        rst = 1'b1;
        send_word(1'b0, 8'hAA, 1'b1, 8);
        for (int i = 0; i < 3; i++) send_slot(1'b1, 1'b1);
        rst = 1'b0;
        v0 = vcount;
        for (int i = 0; i < 4; i++) send_slot(1'b1, 1'b0);
        send_slot(1'b0, 1'b1);
        clks(8);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL startup_err: got %b want 0", err_o); end
        checks++; if (vcount !== v0) begin errors++; $display("FAIL startup_partial_valid: got %0d pulses want 0", vcount - v0); end
        checks++; if (l_data_o !== 8'h00) begin errors++; $display("FAIL startup_l_reset: got %h want 00", l_data_o); end
        send_frame(8'h5A, 8'hC3);
        clks(8);
        checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL startup_valid: got %0d pulses want 1", vcount - v0); end
        checks++; if (last_l !== 8'h5A || last_r !== 8'hC3) begin errors++; $display("FAIL startup_data: got %h/%h want 5a/c3", last_l, last_r); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL startup_err_after: got %b want 0", err_o); end
    endtask

    task automatic test_reset_midop;
        int v0;
        logic [7:0] partial;
        partial = 8'hF0;
        for (int i = 0; i < 4; i++) send_slot(1'b0, partial[7-i]);
        rst = 1'b1;
        clks(2);
        checks++; if (l_data_o !== 8'h00 || r_data_o !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h/%h want 00/00", l_data_o, r_data_o); end
        checks++; if (valid_o !== 1'b0 || err_o !== 1'b0 || peak_o !== 8'h00) begin errors++; $display("FAIL midrst_flags: got v=%b e=%b p=%h want 0/0/00", valid_o, err_o, peak_o); end
        checks++; if (dut.state !== 1'b0) begin errors++; $display("FAIL midrst_state: got %b want HUNT(0)", dut.state); end
        rst = 1'b0;
        v0 = vcount;
        for (int i = 4; i < 7; i++) send_slot(1'b0, partial[7-i]);
        send_slot(1'b1, partial[0]);
        send_word(1'b1, 8'h00, 1'b0, 8);
        send_frame(8'h77, 8'h88);
        clks(8);
        checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL midrst_valid: got %0d pulses want 1", vcount - v0); end
        checks++; if (last_l !== 8'h77 || last_r !== 8'h88) begin errors++; $display("FAIL midrst_data_after: got %h/%h want 77/88", last_l, last_r); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err_o); end
    endtask

    task automatic test_peak;
        logic [7:0] e1, e2, e3;
        int v0;
`ifdef I2S_RX_PEAK_EN
        e1 = 8'h10; e2 = 8'h7F; e3 = 8'h20;
`else
        e1 = 8'h00; e2 = 8'h00; e3 = 8'h00;
`endif
        err_clr_i = 1'b1;
        clks(1);
        err_clr_i = 1'b0;
        clks(1);
        checks++; if (peak_o !== 8'h00) begin errors++; $display("FAIL peak_cleared_start: got %h want 00", peak_o); end
        send_frame(8'h10, 8'hF0);
        clks(8);
        checks++; if (peak_o !== e1) begin errors++; $display("FAIL peak_first: got %h want %h", peak_o, e1); end
        send_frame(8'h80, 8'h05);
        clks(8);
        checks++; if (peak_o !== e2) begin errors++; $display("FAIL peak_saturate: got %h want %h", peak_o, e2); end
        // Clear coincides with the valid cycle of (0x20, 0x01).
        v0 = vcount;
        send_word(1'b0, 8'h20, 1'b1, 8);
        for (int i = 0; i < 7; i++) send_slot(1'b1, 1'b0);
        sck_i = 1'b0;
        ws_i  = 1'b0;
        sd_i  = 1'b1;
        clks(4);
        sck_i = 1'b1;
        clks(2);
        err_clr_i = 1'b1;
        clks(1);
        err_clr_i = 1'b0;
        clks(8);
        checks++; if (vcount !== v0 + 1) begin errors++; $display("FAIL peak_clr_valid: got %0d pulses want 1", vcount - v0); end
        checks++; if (peak_o !== e3) begin errors++; $display("FAIL peak_update_beats_clr: got %h want %h", peak_o, e3); end
        err_clr_i = 1'b1;
        clks(1);
        err_clr_i = 1'b0;
        clks(1);
        checks++; if (peak_o !== 8'h00) begin errors++; $display("FAIL peak_clear: got %h want 00", peak_o); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clks(1);
        test_reset();
        test_nominal();
        test_framing_error();
        test_ws_toggle();
        test_startup_midframe();
        test_reset_midop();
        test_peak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
